// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, register names, IR field positions,
// next-PC select encodings and the fetch FSM state type.
package isa_pkg;

  typedef enum logic [5:0] {
    OP_ADDI  = 6'd1,
    OP_SUB   = 6'd2,
    OP_AND   = 6'd3,
    OP_BGT   = 6'd4,
    OP_JMP   = 6'd5,
    OP_CALL  = 6'd6,
    OP_RET   = 6'd7,
    OP_PUSH  = 6'd8,
    OP_POP   = 6'd9,
    OP_LW    = 6'd10,
    OP_SW    = 6'd11,
    OP_LWPOI = 6'd12
  } opcode_t;

  typedef enum logic [3:0] {
    R0, R1, R2, R3, R4, R5, R6, R7,
    R8, R9, R10, R11, R12, R13, R14, R15
  } reg_t;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RD_HI    = 25;
  localparam int RD_LO    = 22;
  localparam int RS_HI    = 21;
  localparam int RS_LO    = 18;
  localparam int IMM16_HI = 17;
  localparam int IMM16_LO = 2;
  localparam int IMM26_HI = 25;
  localparam int IMM26_LO = 0;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_RET    = 2'd3
  } pc_src_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC mux: sequential, branch, jump/call, return.
module next_pc_calc
  import isa_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] ir,
  input  logic [1:0]         pc_src,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  ret_addr,
  output logic [ADDR_W-1:0]  next_pc
);

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] imm16_sext;
  logic [ADDR_W-1:0] jump_target;
  logic              unused;

  assign pc_inc      = pc + ADDR_W'(1);
  assign imm16_sext  = {{(ADDR_W-16){ir[IMM16_HI]}}, ir[IMM16_HI:IMM16_LO]};
  // Jump keeps the PC's top bits, like a region-relative absolute jump.
  assign jump_target = {pc[ADDR_W-1:IMM26_HI+1], ir[IMM26_HI:IMM26_LO]};
  assign unused      = ^{ir[INSTR_W-1:IMM26_HI+1], ir[IMM16_LO-1:0]};

  always_comb begin
    next_pc = pc_inc;
    case (pc_src_t'(pc_src))
      PC_SEQ:    next_pc = pc_inc;
      PC_BRANCH: next_pc = branch_taken ? pc_inc + imm16_sext : pc_inc;
      PC_JUMP:   next_pc = jump_target;
      PC_RET:    next_pc = ret_addr;
      default:   next_pc = pc_inc;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches into the IR, and hands the
// instruction to control with a valid / pc_update handshake.
module instruction_fetch_unit
  import isa_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                INSTR_W   = 32,
  parameter int                MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] RESET_PC  = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fetch_start,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [ADDR_W-1:0]  addressBus,
  output logic [INSTR_W-1:0] instructionReg,
  output logic               ir_valid,
  output logic               addr_fault,
  input  logic               pc_update,
  input  logic [1:0]         pc_src,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  ret_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus1,
  output logic               busy
);

  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MEM_DEPTH);

  fetch_state_t       state, state_nxt;
  logic [ADDR_W-1:0]  pc_q, next_pc;
  logic [INSTR_W-1:0] ir_q;
  logic               fault_q;
  logic               in_range;
  logic               retire;

  assign in_range       = pc_q < DEPTH;
  assign retire         = (state == S_HOLD) && pc_update;
  assign pc             = pc_q;
  assign addressBus     = pc_q;
  assign pc_plus1       = pc_q + ADDR_W'(1);
  assign instructionReg = ir_q;
  assign ir_valid       = (state == S_HOLD);
  assign addr_fault     = fault_q;
  assign busy           = (state != S_IDLE);

  next_pc_calc #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_next_pc (
    .pc           (pc_q),
    .ir           (ir_q),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .ret_addr     (ret_addr),
    .next_pc      (next_pc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fetch_start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_HOLD;
      // fetch_start without pc_update is ignored: the IR is never refetched.
      S_HOLD:  if (pc_update) state_nxt = fetch_start ? S_FETCH : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) begin
        ir_q    <= in_range ? instr_in : '0;
        fault_q <= !in_range;
      end
      if (retire) pc_q <= next_pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational memory model.
module tb_instruction_fetch_unit;
  import isa_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_start = 1'b0;
  logic [31:0] instr_in;
  logic [31:0] addressBus;
  logic [31:0] instructionReg;
  logic        ir_valid;
  logic        addr_fault;
  logic        pc_update = 1'b0;
  logic [1:0]  pc_src = 2'd0;
  logic        branch_taken = 1'b0;
  logic [31:0] ret_addr = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus1;
  logic        busy;

  logic [31:0] mem [0:511];
  int checks = 0;
  int failures = 0;

  instruction_fetch_unit dut (
    .clock(clock), .reset(reset), .fetch_start(fetch_start), .instr_in(instr_in),
    .addressBus(addressBus), .instructionReg(instructionReg), .ir_valid(ir_valid),
    .addr_fault(addr_fault), .pc_update(pc_update), .pc_src(pc_src),
    .branch_taken(branch_taken), .ret_addr(ret_addr), .pc(pc),
    .pc_plus1(pc_plus1), .busy(busy)
  );

  always #5 clock = ~clock;

  assign instr_in = (addressBus < 32'd512) ? mem[addressBus[8:0]] : 32'hCAFE_F00D;

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [3:0] rd, logic [3:0] rs,
                                        logic [15:0] imm);
    return {op, rd, rs, imm, 2'b00};
  endfunction

  function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_fetch();
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
  endtask

  task automatic retire(input logic [1:0] src, input logic taken, input logic [31:0] ra,
                        input logic fs);
    pc_update = 1'b1; pc_src = src; branch_taken = taken; ret_addr = ra; fetch_start = fs;
    tick();
    pc_update = 1'b0; pc_src = 2'd0; branch_taken = 1'b0; fetch_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (pc !== 32'd1) begin failures++; $display("FAIL reset_pc got=%0d exp=1", pc); end
    checks++; if (addressBus !== 32'd1) begin failures++; $display("FAIL reset_abus got=%0d exp=1", addressBus); end
    checks++; if (pc_plus1 !== 32'd2) begin failures++; $display("FAIL reset_pcp1 got=%0d exp=2", pc_plus1); end
    checks++; if ({ir_valid, addr_fault, busy} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {ir_valid, addr_fault, busy}); end
    checks++; if (instructionReg !== 32'd0) begin failures++; $display("FAIL reset_ir got=%h exp=0", instructionReg); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    retire(2'd1, 1'b1, 32'd99, 1'b0);  // pc_update in IDLE must be ignored
    checks++; if (pc !== 32'd1 || busy !== 1'b0) begin failures++; $display("FAIL idle_update pc=%0d busy=%b exp pc=1 busy=0", pc, busy); end
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    checks++; if (busy !== 1'b1 || ir_valid !== 1'b0) begin failures++; $display("FAIL fetch_cycle busy=%b ir_valid=%b exp 1/0", busy, ir_valid); end
    tick();
    checks++; if (instructionReg !== 32'h0440_0008) begin failures++; $display("FAIL fetch_ir got=%h exp=04400008", instructionReg); end
    checks++; if (ir_valid !== 1'b1 || addressBus !== 32'd1) begin failures++; $display("FAIL fetch_hold ir_valid=%b abus=%0d exp 1/1", ir_valid, addressBus); end
  endtask

  task automatic test_branch();
    retire(2'd0, 1'b0, 32'd0, 1'b0);
    checks++; if (pc !== 32'd2 || ir_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL seq pc=%0d iv=%b busy=%b exp 2/0/0", pc, ir_valid, busy); end
    do_fetch();
    retire(2'd0, 1'b0, 32'd0, 1'b0);
    do_fetch();
    checks++; if (instructionReg !== mem[3]) begin failures++; $display("FAIL bgt_ir got=%h exp=%h", instructionReg, mem[3]); end
    retire(2'd1, 1'b1, 32'd0, 1'b0);
    checks++; if (pc !== 32'd6) begin failures++; $display("FAIL branch_taken got=%0d exp=6", pc); end
    do_fetch();
    retire(2'd2, 1'b0, 32'd0, 1'b0);
    checks++; if (pc !== 32'd3) begin failures++; $display("FAIL jmp_back got=%0d exp=3", pc); end
    do_fetch();
    retire(2'd1, 1'b0, 32'd0, 1'b0);
    checks++; if (pc !== 32'd4) begin failures++; $display("FAIL branch_not_taken got=%0d exp=4", pc); end
  endtask

  task automatic test_jump_call();
    do_fetch();
    retire(2'd0, 1'b0, 32'd0, 1'b0);
    do_fetch();
    retire(2'd2, 1'b0, 32'd0, 1'b0);
    checks++; if (pc !== 32'd7) begin failures++; $display("FAIL jmp got=%0d exp=7", pc); end
    do_fetch();
    checks++; if (pc_plus1 !== 32'd8) begin failures++; $display("FAIL call_link got=%0d exp=8", pc_plus1); end
    retire(2'd2, 1'b0, 32'd0, 1'b0);
    checks++; if (pc !== 32'd10) begin failures++; $display("FAIL call got=%0d exp=10", pc); end
    do_fetch();
    retire(2'd3, 1'b0, 32'd8, 1'b0);
    checks++; if (pc !== 32'd8) begin failures++; $display("FAIL ret got=%0d exp=8", pc); end
    do_fetch();
    retire(2'd1, 1'b1, 32'd0, 1'b0);
    checks++; if (pc !== 32'd6) begin failures++; $display("FAIL branch_neg got=%0d exp=6", pc); end
  endtask

  task automatic test_back_to_back();
    do_fetch();
    fetch_start = 1'b1;
    tick(); tick();
    fetch_start = 1'b0;
    checks++; if (instructionReg !== mem[6] || ir_valid !== 1'b1 || pc !== 32'd6) begin failures++; $display("FAIL hold_refetch ir=%h iv=%b pc=%0d exp %h/1/6", instructionReg, ir_valid, pc, mem[6]); end
    retire(2'd2, 1'b0, 32'd0, 1'b1);
    checks++; if (pc !== 32'd3 || addressBus !== 32'd3 || ir_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_fetch pc=%0d iv=%b busy=%b exp 3/0/1", pc, ir_valid, busy); end
    tick();
    checks++; if (instructionReg !== mem[3] || ir_valid !== 1'b1) begin failures++; $display("FAIL b2b_ir1 got=%h iv=%b exp=%h/1", instructionReg, ir_valid, mem[3]); end
    retire(2'd1, 1'b0, 32'd0, 1'b1);
    tick();
    checks++; if (instructionReg !== mem[4] || pc !== 32'd4 || ir_valid !== 1'b1) begin failures++; $display("FAIL b2b_ir2 got=%h pc=%0d exp=%h/4", instructionReg, pc, mem[4]); end
    retire(2'd2, 1'b0, 32'd0, 1'b0);
    checks++; if (pc !== 32'd255 || busy !== 1'b0) begin failures++; $display("FAIL jmp255 pc=%0d busy=%b exp 255/0", pc, busy); end
  endtask

  task automatic test_fault();
    do_fetch();
    checks++; if (instructionReg !== mem[255] || addr_fault !== 1'b0) begin failures++; $display("FAIL fetch255 ir=%h fault=%b exp %h/0", instructionReg, addr_fault, mem[255]); end
    retire(2'd0, 1'b0, 32'd0, 1'b1);
    tick();
    checks++; if (pc !== 32'd256 || addr_fault !== 1'b1 || instructionReg !== 32'd0 || ir_valid !== 1'b1) begin failures++; $display("FAIL fetch256 pc=%0d fault=%b ir=%h iv=%b exp 256/1/0/1", pc, addr_fault, instructionReg, ir_valid); end
    retire(2'd3, 1'b0, 32'd1, 1'b0);
    checks++; if (addr_fault !== 1'b1 || pc !== 32'd1) begin failures++; $display("FAIL fault_sticky fault=%b pc=%0d exp 1/1", addr_fault, pc); end
    do_fetch();
    checks++; if (addr_fault !== 1'b0 || instructionReg !== mem[1]) begin failures++; $display("FAIL fault_clear fault=%b ir=%h exp 0/%h", addr_fault, instructionReg, mem[1]); end
    retire(2'd3, 1'b0, 32'hFFFF_FFFF, 1'b0);
    checks++; if (pc_plus1 !== 32'd0) begin failures++; $display("FAIL wrap_pcp1 got=%h exp=0", pc_plus1); end
    do_fetch();
    checks++; if (addr_fault !== 1'b1 || instructionReg !== 32'd0) begin failures++; $display("FAIL fault_top fault=%b ir=%h exp 1/0", addr_fault, instructionReg); end
    retire(2'd0, 1'b0, 32'd0, 1'b0);
    checks++; if (pc !== 32'd0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", pc); end
  endtask

  task automatic test_reset_mid();
    do_fetch();
    retire(2'd3, 1'b0, 32'd2, 1'b1);
    tick();
    retire(2'd0, 1'b0, 32'd0, 1'b1);
    checks++; if (pc !== 32'd3 || busy !== 1'b1 || instructionReg !== mem[2]) begin failures++; $display("FAIL pre_reset pc=%0d busy=%b ir=%h exp 3/1/%h", pc, busy, instructionReg, mem[2]); end
    reset = 1'b1;
    #1;
    checks++; if (pc !== 32'd1 || ir_valid !== 1'b0 || busy !== 1'b0 || instructionReg !== 32'd0) begin failures++; $display("FAIL reset_mid pc=%0d iv=%b busy=%b ir=%h exp 1/0/0/0", pc, ir_valid, busy, instructionReg); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (instructionReg !== 32'd0 || busy !== 1'b0 || pc !== 32'd1) begin failures++; $display("FAIL post_reset ir=%h busy=%b pc=%0d exp 0/0/1", instructionReg, busy, pc); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[1]   = enc_i(OP_ADDI, R1, R0, 16'd2);
    mem[2]   = enc_i(OP_SUB, R2, R1, 16'd0);
    mem[3]   = enc_i(OP_BGT, R1, R2, 16'd2);
    mem[4]   = enc_j(OP_JMP, 26'd255);
    mem[5]   = enc_j(OP_JMP, 26'd7);
    mem[6]   = enc_j(OP_JMP, 26'd3);
    mem[7]   = enc_j(OP_CALL, 26'd10);
    mem[8]   = enc_i(OP_BGT, R3, R4, 16'hFFFD);
    mem[10]  = enc_j(OP_RET, 26'd0);
    mem[255] = enc_i(OP_LW, R5, R6, 16'd4);
    mem[256] = 32'hDEAD_BEEF;
    test_reset();
    test_fetch();
    test_branch();
    test_jump_call();
    test_back_to_back();
    test_fault();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
